// File: rtl/app_data_reader_pkg.sv
// Shared definitions for the app data reader: default parameters, FSM encoding, header layout.
// Header word = granted app id zero-extended to the stream width.
package app_data_reader_pkg;
    localparam int RAH_TOTAL_APPS   = 8;
    localparam int RAH_APP_ID_WIDTH = 3;
    localparam int RAH_DATA_WIDTH   = 48;
    localparam int RAH_BURST_LEN    = 16;
    localparam int RAH_CNT_WIDTH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_POP,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } rah_state_e;

    function automatic logic app_in_range(input int unsigned id, input int unsigned total);
        return id < total;
    endfunction
endpackage

// File: rtl/app_data_reader_if.sv
// Grant, per-app queue and output stream signals of the app data reader.
// master = reader side, slave = grant source / queues / stream sink.
interface app_data_reader_if
    import app_data_reader_pkg::*;
#(
    parameter int TOTAL_APPS   = RAH_TOTAL_APPS,
    parameter int APP_ID_WIDTH = RAH_APP_ID_WIDTH,
    parameter int DATA_WIDTH   = RAH_DATA_WIDTH
);
    logic                             read_queue;
    logic [APP_ID_WIDTH-1:0]          app_id;
    logic [TOTAL_APPS-1:0]            data_queue_empty;
    logic [TOTAL_APPS-1:0]            rd_en;
    logic [TOTAL_APPS*DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_last;
    logic                             out_ready;
    logic                             is_busy;
    logic                             read_done;

    modport master (
        input  read_queue, app_id, data_queue_empty, rd_data, out_ready,
        output rd_en, out_data, out_valid, out_last, is_busy, read_done
    );

    modport slave (
        output read_queue, app_id, data_queue_empty, rd_data, out_ready,
        input  rd_en, out_data, out_valid, out_last, is_busy, read_done
    );
endinterface

// File: rtl/app_data_reader_word_mux.sv
// Selects one app's read word out of the flattened queue read bus; pure combinational.
// Out-of-range selects yield zero.
module app_word_mux #(
    parameter int TOTAL_APPS   = 8,
    parameter int APP_ID_WIDTH = 3,
    parameter int DATA_WIDTH   = 48
) (
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] i_rd_data,
    input  logic [APP_ID_WIDTH-1:0]          i_sel,
    output logic [DATA_WIDTH-1:0]            o_word
);
    always_comb begin
        o_word = '0;
        for (int i = 0; i < TOTAL_APPS; i++) begin
            if (i_sel == APP_ID_WIDTH'(i)) begin
                o_word = i_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: rtl/app_data_reader.sv
// Per grant: one header word then up to BURST_LEN words popped from the granted app queue.
// Queue read latency one cycle; out_data/out_last held while out_valid && !out_ready.
module app_data_reader
    import app_data_reader_pkg::*;
#(
    parameter int TOTAL_APPS   = RAH_TOTAL_APPS,
    parameter int APP_ID_WIDTH = RAH_APP_ID_WIDTH,
    parameter int DATA_WIDTH   = RAH_DATA_WIDTH,
    parameter int BURST_LEN    = RAH_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    app_data_reader_if.master bus
);
    rah_state_e               r_state;
    rah_state_e               w_state_nxt;
    logic [APP_ID_WIDTH-1:0]  r_sel;
    logic                     r_sel_ok;
    logic                     r_last;
    logic [RAH_CNT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [DATA_WIDTH-1:0]    w_word;
    logic                     w_req_ok;
    logic                     w_req_empty;
    logic                     w_empty_sel;
    logic                     w_pop;

    app_word_mux #(
        .TOTAL_APPS  (TOTAL_APPS),
        .APP_ID_WIDTH(APP_ID_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_word_mux (
        .i_rd_data(bus.rd_data),
        .i_sel    (r_sel),
        .o_word   (w_word)
    );

    // Out-of-range apps look permanently empty, so they never get popped.
    assign w_req_ok    = app_in_range(32'(bus.app_id), TOTAL_APPS);
    assign w_req_empty = w_req_ok ? bus.data_queue_empty[bus.app_id] : 1'b1;
    assign w_empty_sel = r_sel_ok ? bus.data_queue_empty[r_sel] : 1'b1;
    assign w_pop       = (r_state == ST_POP) && !w_empty_sel;

    assign bus.out_data = r_out_data;
    assign bus.is_busy  = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.rd_en     = '0;
        bus.read_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.read_queue) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                bus.out_valid = 1'b1;
                bus.out_last  = r_last;
                if (bus.out_ready) w_state_nxt = r_last ? ST_DONE : ST_POP;
            end
            ST_POP: begin
                if (w_pop) begin
                    bus.rd_en   = TOTAL_APPS'(1) << r_sel;
                    w_state_nxt = ST_LATCH;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_LATCH: w_state_nxt = ST_SEND;
            ST_SEND: begin
                bus.out_valid = 1'b1;
                bus.out_last  = r_last;
                if (bus.out_ready) w_state_nxt = r_last ? ST_DONE : ST_POP;
            end
            ST_DONE: begin
                bus.read_done = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_sel_ok   <= 1'b0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.read_queue) begin
                        r_sel      <= bus.app_id;
                        r_sel_ok   <= w_req_ok;
                        r_last     <= w_req_empty;
                        r_out_data <= DATA_WIDTH'(bus.app_id);
                    end
                end
                ST_POP: begin
                    if (w_pop) r_cnt <= r_cnt + RAH_CNT_WIDTH'(1);
                end
                ST_LATCH: begin
                    // Empty is sampled after the pop, so it reflects whether more words remain.
                    r_out_data <= w_word;
                    r_last     <= (r_cnt == RAH_CNT_WIDTH'(BURST_LEN)) || w_empty_sel;
                end
                ST_DONE: r_cnt <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_app_data_reader.sv
// Directed bench for app_data_reader: queue model with one-cycle read latency and an
// output scoreboard of expected {data,last} words checked at every handshake.
module tb_app_data_reader;
    localparam int NA = 8;
    localparam int AW = 3;
    localparam int DW = 48;
    localparam int BL = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   rd_cnt [NA];
    int   seq = 0;

    logic [DW-1:0] mq [NA][$];
    exp_t          sb [$];

    logic          hold_vld = 1'b0;
    logic [DW-1:0] hold_dat;
    logic          hold_last;

    app_data_reader_if #(.TOTAL_APPS(NA), .APP_ID_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    app_data_reader #(
        .TOTAL_APPS  (NA),
        .APP_ID_WIDTH(AW),
        .DATA_WIDTH  (DW),
        .BURST_LEN   (BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Queue model: registered read data, empty flags updated after the pop edge.
    always @(posedge clk) begin
        logic [NA-1:0] emp;
        for (int i = 0; i < NA; i++) begin
            if (bus.rd_en[i] && mq[i].size() != 0) begin
                bus.rd_data[i*DW +: DW] <= mq[i].pop_front();
            end
            emp[i] = (mq[i].size() == 0);
        end
        bus.data_queue_empty <= emp;
    end

    // Monitor: scoreboard compare on handshake, hold-stability, pop legality, done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b0) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                n_tests++;
                assert (bus.out_valid === 1'b1 && bus.out_data === hold_dat && bus.out_last === hold_last)
                else begin
                    n_fail++;
                    $error("FAIL hold_stable: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                           bus.out_valid, bus.out_data, bus.out_last, hold_dat, hold_last);
                end
            end
            hold_vld  = bus.out_valid && !bus.out_ready;
            hold_dat  = bus.out_data;
            hold_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                assert (sb.size() != 0)
                else begin
                    n_fail++;
                    $error("FAIL unexpected_word: got d=%h l=%b, expected no word", bus.out_data, bus.out_last);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_tests++;
                    assert (bus.out_data === e.d && bus.out_last === e.l)
                    else begin
                        n_fail++;
                        $error("FAIL stream_word: got d=%h l=%b, expected d=%h l=%b",
                               bus.out_data, bus.out_last, e.d, e.l);
                    end
                end
            end
            for (int i = 0; i < NA; i++) begin
                if (bus.rd_en[i]) begin
                    rd_cnt[i]++;
                    n_tests++;
                    assert (bus.data_queue_empty[i] === 1'b0)
                    else begin
                        n_fail++;
                        $error("FAIL pop_on_empty: got rd_en[%0d]=1 with empty=1, expected no pop", i);
                    end
                end
            end
            if (bus.read_done === 1'b1) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int app, input int n);
        for (int k = 0; k < n; k++) begin
            mq[app].push_back({16'hD000 | 16'(app), 32'(seq)});
            seq++;
        end
    endtask

    // Expected output of one grant, derived from the bench's own queue contents.
    task automatic expect_grant(input int app);
        int n;
        exp_t e;
        n = (app < NA) ? ((mq[app].size() > BL) ? BL : mq[app].size()) : 0;
        e.d = DW'(app);
        e.l = (n == 0);
        sb.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.d = mq[app][k];
            e.l = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic grant(input int app);
        bus.read_queue = 1'b1;
        bus.app_id     = AW'(app);
        cyc(1);
        bus.read_queue = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, input bit rnd);
        int k;
        k = 0;
        while (bus.is_busy === 1'b1 && k < 400) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            cyc(1);
            k++;
        end
        bus.out_ready = 1'b1;
        chk({tag, "_idle_in_budget"}, 64'(bus.is_busy), 64'd0);
    endtask

    initial begin
        int d0;
        int r0;
        int r1;
        for (int i = 0; i < NA; i++) rd_cnt[i] = 0;
        rst            = 1'b1;
        bus.read_queue = 1'b0;
        bus.app_id     = '0;
        bus.out_ready  = 1'b1;
        cyc(3);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_rd_en",     64'(bus.rd_en),     64'd0);
        chk("rst_read_done", 64'(bus.read_done), 64'd0);
        chk("rst_is_busy",   64'(bus.is_busy),   64'd0);
        rst = 1'b0;
        cyc(1);

        // App 2, three words, always ready
        load(2, 3);
        cyc(1);
        d0 = done_cnt; r0 = rd_cnt[2];
        expect_grant(2);
        grant(2);
        chk("t1_busy", 64'(bus.is_busy), 64'd1);
        run_to_idle("t1", 1'b0);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_pops", 64'(rd_cnt[2] - r0), 64'd3);
        chk("t1_sb_drained", 64'(sb.size()), 64'd0);
        chk("t1_queue_left", 64'(mq[2].size()), 64'd0);

        // App 5, empty queue: header only
        d0 = done_cnt; r0 = rd_cnt[5];
        expect_grant(5);
        grant(5);
        run_to_idle("t2", 1'b0);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_pops", 64'(rd_cnt[5] - r0), 64'd0);
        chk("t2_sb_drained", 64'(sb.size()), 64'd0);

        // App 0, 40 words: burst limit
        load(0, 40);
        cyc(1);
        d0 = done_cnt; r0 = rd_cnt[0];
        expect_grant(0);
        grant(0);
        run_to_idle("t3", 1'b0);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t3_pops", 64'(rd_cnt[0] - r0), 64'd16);
        chk("t3_queue_left", 64'(mq[0].size()), 64'd24);
        chk("t3_sb_drained", 64'(sb.size()), 64'd0);

        // App 4, random backpressure
        load(4, 10);
        cyc(1);
        d0 = done_cnt;
        expect_grant(4);
        grant(4);
        run_to_idle("t4", 1'b1);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t4_sb_drained", 64'(sb.size()), 64'd0);
        chk("t4_queue_left", 64'(mq[4].size()), 64'd0);

        // Grant for app 1 while app 3 is busy must be ignored
        load(3, 5);
        load(1, 2);
        cyc(1);
        d0 = done_cnt; r0 = rd_cnt[3]; r1 = rd_cnt[1];
        expect_grant(3);
        grant(3);
        cyc(2);
        grant(1);
        run_to_idle("t5", 1'b0);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_pops_app3", 64'(rd_cnt[3] - r0), 64'd5);
        chk("t5_pops_app1", 64'(rd_cnt[1] - r1), 64'd0);
        chk("t5_app1_left", 64'(mq[1].size()), 64'd2);
        chk("t5_sb_drained", 64'(sb.size()), 64'd0);

        // Reset while holding a data word in SEND
        load(6, 4);
        cyc(1);
        d0 = done_cnt; r0 = rd_cnt[6];
        sb.push_back('{d: DW'(6), l: 1'b0});
        bus.out_ready = 1'b0;
        grant(6);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        cyc(2);
        chk("t6_in_send_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_out_last",  64'(bus.out_last),  64'd0);
        chk("t6_rst_out_data",  64'(bus.out_data),  64'd0);
        chk("t6_rst_rd_en",     64'(bus.rd_en),     64'd0);
        chk("t6_rst_busy",      64'(bus.is_busy),   64'd0);
        chk("t6_no_done",       64'(done_cnt - d0), 64'd0);
        chk("t6_one_pop",       64'(rd_cnt[6] - r0), 64'd1);
        chk("t6_hdr_consumed",  64'(sb.size()),     64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cyc(1);
        chk("t6_queue_after_rst", 64'(mq[6].size()), 64'd3);
        d0 = done_cnt;
        expect_grant(6);
        grant(6);
        run_to_idle("t6b", 1'b0);
        chk("t6b_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t6b_sb_drained", 64'(sb.size()), 64'd0);
        chk("t6b_queue_left", 64'(mq[6].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
